// File: rtl/gearbox_tx_66to32_pkg.sv
// Shared constants and types for the 66b/32b transmit gearbox. The header
// encodings are also used by the RX header seeker.
package gearbox_tx_66to32_pkg;

  localparam logic [1:0]  C_DATA_HEADER    = 2'b01;
  localparam logic [1:0]  C_CMD_HEADER     = 2'b10;
  localparam int          BLK_W            = 66;
  localparam int          WORD_W           = 32;
  localparam int          WORDS_PER_PERIOD = 33;
  localparam int          BLKS_PER_PERIOD  = 16;
  localparam logic [63:0] C_IDLE_PAYLOAD   = 64'h7800_0000_0000_0000;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } blk66_t;

  // Only 01 and 10 are legal sync headers on the line.
  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

endpackage

// File: rtl/gearbox_tx_66to32.sv
// 66b block to 32b word transmit gearbox. Keeps the line full by inserting
// idle command blocks whenever the framer has nothing ready at a load slot.
module gearbox_tx_66to32
  import gearbox_tx_66to32_pkg::*;
#(
  parameter logic [1:0]  IDLE_HDR     = C_CMD_HEADER,
  parameter logic [63:0] IDLE_PAYLOAD = C_IDLE_PAYLOAD,
  parameter int          BUF_W        = 98
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [65:0]  blk_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic         word_rd_i,
  output logic [31:0]  word_o,
  output logic         word_dv_o,
  output logic [5:0]   phase_o,
  output logic         idle_ins_o,
  output logic         hdr_err_o
);

  logic [6:0]       fill_q;
  logic [BUF_W-1:0] buf_q;
  logic             load;
  blk66_t           blk_sel;
  logic [BUF_W-1:0] blk_ext;
  logic [BUF_W-1:0] combined;
  logic [6:0]       fill_next;

  // Handshake: a block transfers on an edge where blk_valid_i, blk_ready_o
  // and word_rd_i are all high; ready never looks at valid, and an offered
  // block must be held stable by the source until it transfers.
  assign load        = (fill_q < 7'd32);
  assign blk_ready_o = word_rd_i & load;

  always_comb begin
    blk_sel = blk_valid_i ? blk66_t'(blk_i) : blk66_t'({IDLE_HDR, IDLE_PAYLOAD});
    blk_ext = {blk_sel, {(BUF_W-BLK_W){1'b0}}} >> fill_q;
    if (load) begin
      combined  = buf_q | blk_ext;
      fill_next = fill_q + 7'd66;
    end else begin
      combined  = buf_q;
      fill_next = fill_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q     <= '0;
      buf_q      <= '0;
      phase_o    <= '0;
      word_o     <= '0;
      word_dv_o  <= 1'b0;
      idle_ins_o <= 1'b0;
      hdr_err_o  <= 1'b0;
    end else if (word_rd_i) begin
      word_o     <= combined[BUF_W-1 -: WORD_W];
      buf_q      <= combined << WORD_W;
      fill_q     <= fill_next - 7'd32;
      word_dv_o  <= 1'b1;
      phase_o    <= (phase_o == 6'(WORDS_PER_PERIOD-1)) ? 6'd0 : phase_o + 6'd1;
      idle_ins_o <= load & ~blk_valid_i;
      hdr_err_o  <= load & blk_valid_i & hdr_invalid(blk_sel.hdr);
    end else begin
      idle_ins_o <= 1'b0;
      hdr_err_o  <= 1'b0;
    end
  end

  // 16 loads per 33 words means the buffer drains exactly at each phase wrap.
  fill_phase_lock: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fill_q == 7'd0) == (phase_o == 6'd0));

endmodule
